write_address_decoder: RTL and testbench

WRITE_ADDRESS_DECODER -- requirements
Module: write_address_decoder

---
 rtl/write_address_decoder.sv | 199 +++++++++++++++++++
 tb/tb_write_address_decoder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_address_decoder.sv
// ---------------------------------------------------------------------------
// write_address_decoder
//
// Decodes AXI write-address (AW) requests from one master onto three
// slave-side arbiters using awaddr[11:10]:
//   00 -> s0, 01 -> s1, 10 -> s2, 11 -> decode error (no slave).
// The accepted AW is held in a single output register until the selected
// slave takes it. Every accepted AW, decode errors included, also pushes a
// {sel, awid} entry into a small route FIFO so the W router can steer data
// beats in AW acceptance order.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   s_axi_aw*                     master AW payload and valid/ready
//   aw_decoder_*_sN (N = 0..2)    payload, valid and ready per slave arbiter
//   w_route_valid/sel/id          head of the route FIFO (sel 2'b11 = error)
//   w_route_pop                   W router consumed the head entry
//   dec_err                       one-cycle pulse after an unmapped accept
// ---------------------------------------------------------------------------
module write_address_decoder #(
    parameter int ROUTE_DEPTH = 4,
    parameter int ROUTE_AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [11:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic [5:0]  s_axi_awid,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,

    output logic [11:0] aw_decoder_awaddr_s0,
    output logic [7:0]  aw_decoder_awlen_s0,
    output logic [2:0]  aw_decoder_awsize_s0,
    output logic [1:0]  aw_decoder_awburst_s0,
    output logic [5:0]  aw_decoder_awid_s0,
    output logic        aw_decoder_valid_s0,
    input  logic        aw_decoder_ready_s0,

    output logic [11:0] aw_decoder_awaddr_s1,
    output logic [7:0]  aw_decoder_awlen_s1,
    output logic [2:0]  aw_decoder_awsize_s1,
    output logic [1:0]  aw_decoder_awburst_s1,
    output logic [5:0]  aw_decoder_awid_s1,
    output logic        aw_decoder_valid_s1,
    input  logic        aw_decoder_ready_s1,

    output logic [11:0] aw_decoder_awaddr_s2,
    output logic [7:0]  aw_decoder_awlen_s2,
    output logic [2:0]  aw_decoder_awsize_s2,
    output logic [1:0]  aw_decoder_awburst_s2,
    output logic [5:0]  aw_decoder_awid_s2,
    output logic        aw_decoder_valid_s2,
    input  logic        aw_decoder_ready_s2,

    output logic        w_route_valid,
    output logic [1:0]  w_route_sel,
    output logic [5:0]  w_route_id,
    input  logic        w_route_pop,

    output logic        dec_err
);

    typedef enum logic [1:0] {
        SEL_S0  = 2'b00,
        SEL_S1  = 2'b01,
        SEL_S2  = 2'b10,
        SEL_ERR = 2'b11
    } sel_e;

    localparam int PAYLOAD_W = 31;
    localparam logic [ROUTE_AW:0] FULL_COUNT = (ROUTE_AW + 1)'(ROUTE_DEPTH);

    // ------------------------------------------------------------------
    // Decode and handshake
    // ------------------------------------------------------------------
    sel_e                 in_sel;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 accept;
    logic                 accept_mapped;

    logic                 hold_valid;
    sel_e                 hold_sel;
    logic [PAYLOAD_W-1:0] hold_payload;
    logic                 sel_ready;
    logic                 hold_fire;

    logic                 route_full;
    logic                 route_push;
    logic                 route_pop;

    assign in_sel     = sel_e'(s_axi_awaddr[11:10]);
    assign in_payload = {s_axi_awaddr, s_axi_awlen, s_axi_awsize,
                         s_axi_awburst, s_axi_awid};

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_ready = 1'b0;
        case (hold_sel)
            SEL_S0:  sel_ready = aw_decoder_ready_s0;
            SEL_S1:  sel_ready = aw_decoder_ready_s1;
            SEL_S2:  sel_ready = aw_decoder_ready_s2;
            default: sel_ready = 1'b0;
        endcase
    end

    assign hold_fire = hold_valid && sel_ready;

    // rst_n gates awready so the master sees no ready while reset is held,
    // even though the registered terms alone would allow an accept.
    assign s_axi_awready = rst_n && (!hold_valid || hold_fire) && !route_full;

    assign accept        = s_axi_awvalid && s_axi_awready;
    assign accept_mapped = accept && (in_sel != SEL_ERR);

    // ------------------------------------------------------------------
    // Output holding register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid   <= 1'b0;
            hold_sel     <= SEL_S0;
            hold_payload <= '0;
            dec_err      <= 1'b0;
        end else begin
            if (accept_mapped) begin
                // Also covers fire-and-reload in the same cycle (no bubble).
                hold_valid   <= 1'b1;
                hold_sel     <= in_sel;
                hold_payload <= in_payload;
            end else if (hold_fire) begin
                hold_valid   <= 1'b0;
            end
            dec_err <= accept && (in_sel == SEL_ERR);
        end
    end

    assign aw_decoder_valid_s0 = hold_valid && (hold_sel == SEL_S0);
    assign aw_decoder_valid_s1 = hold_valid && (hold_sel == SEL_S1);
    assign aw_decoder_valid_s2 = hold_valid && (hold_sel == SEL_S2);

    // Every slave sees the same held payload; only its valid differs.
    assign {aw_decoder_awaddr_s0, aw_decoder_awlen_s0, aw_decoder_awsize_s0,
            aw_decoder_awburst_s0, aw_decoder_awid_s0} = hold_payload;
    assign {aw_decoder_awaddr_s1, aw_decoder_awlen_s1, aw_decoder_awsize_s1,
            aw_decoder_awburst_s1, aw_decoder_awid_s1} = hold_payload;
    assign {aw_decoder_awaddr_s2, aw_decoder_awlen_s2, aw_decoder_awsize_s2,
            aw_decoder_awburst_s2, aw_decoder_awid_s2} = hold_payload;

    // ------------------------------------------------------------------
    // Route FIFO: {sel, awid} per accepted AW, in acceptance order
    // ------------------------------------------------------------------
    logic [7:0]          route_mem [ROUTE_DEPTH];
    logic [ROUTE_AW-1:0] wr_ptr;
    logic [ROUTE_AW-1:0] rd_ptr;
    logic [ROUTE_AW:0]   count;
    logic [7:0]          route_head;

    assign route_full    = (count == FULL_COUNT);
    assign w_route_valid = (count != '0);
    assign route_push    = accept;
    assign route_pop     = w_route_pop && w_route_valid;

    // NOTE: the storage array has no reset; entries are only observable
    // through w_route_valid, which is driven by the reset count.
    always_ff @(posedge clk) begin
        if (route_push) begin
            route_mem[wr_ptr] <= {in_sel, s_axi_awid};
        end
    end

    // Pointers are exactly ROUTE_AW bits, so they wrap modulo ROUTE_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (route_push) wr_ptr <= wr_ptr + 1'b1;
            if (route_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({route_push, route_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign route_head  = route_mem[rd_ptr];
    assign w_route_sel = route_head[7:6];
    assign w_route_id  = route_head[5:0];

endmodule

// File: tb/tb_write_address_decoder.sv
// ---------------------------------------------------------------------------
// tb_write_address_decoder
//
// Directed scenarios followed by a randomized phase. A behavioural model
// (holding slot plus a queue of route entries) predicts every output each
// cycle; inputs change 1 ns after the rising edge and outputs are compared
// 1 ns later.
// ---------------------------------------------------------------------------
module tb_write_address_decoder;

    localparam int ROUTE_DEPTH = 4;
    localparam int ROUTE_AW    = 2;

    logic        clk;
    logic        rst_n;

    logic [11:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic [5:0]  s_axi_awid;
    logic        s_axi_awvalid;
    logic        s_axi_awready;

    logic [11:0] awaddr_s0, awaddr_s1, awaddr_s2;
    logic [7:0]  awlen_s0, awlen_s1, awlen_s2;
    logic [2:0]  awsize_s0, awsize_s1, awsize_s2;
    logic [1:0]  awburst_s0, awburst_s1, awburst_s2;
    logic [5:0]  awid_s0, awid_s1, awid_s2;
    logic        valid_s0, valid_s1, valid_s2;
    logic        ready_s0, ready_s1, ready_s2;

    logic        w_route_valid;
    logic [1:0]  w_route_sel;
    logic [5:0]  w_route_id;
    logic        w_route_pop;
    logic        dec_err;

    write_address_decoder #(
        .ROUTE_DEPTH(ROUTE_DEPTH),
        .ROUTE_AW   (ROUTE_AW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .s_axi_awaddr         (s_axi_awaddr),
        .s_axi_awlen          (s_axi_awlen),
        .s_axi_awsize         (s_axi_awsize),
        .s_axi_awburst        (s_axi_awburst),
        .s_axi_awid           (s_axi_awid),
        .s_axi_awvalid        (s_axi_awvalid),
        .s_axi_awready        (s_axi_awready),
        .aw_decoder_awaddr_s0 (awaddr_s0),
        .aw_decoder_awlen_s0  (awlen_s0),
        .aw_decoder_awsize_s0 (awsize_s0),
        .aw_decoder_awburst_s0(awburst_s0),
        .aw_decoder_awid_s0   (awid_s0),
        .aw_decoder_valid_s0  (valid_s0),
        .aw_decoder_ready_s0  (ready_s0),
        .aw_decoder_awaddr_s1 (awaddr_s1),
        .aw_decoder_awlen_s1  (awlen_s1),
        .aw_decoder_awsize_s1 (awsize_s1),
        .aw_decoder_awburst_s1(awburst_s1),
        .aw_decoder_awid_s1   (awid_s1),
        .aw_decoder_valid_s1  (valid_s1),
        .aw_decoder_ready_s1  (ready_s1),
        .aw_decoder_awaddr_s2 (awaddr_s2),
        .aw_decoder_awlen_s2  (awlen_s2),
        .aw_decoder_awsize_s2 (awsize_s2),
        .aw_decoder_awburst_s2(awburst_s2),
        .aw_decoder_awid_s2   (awid_s2),
        .aw_decoder_valid_s2  (valid_s2),
        .aw_decoder_ready_s2  (ready_s2),
        .w_route_valid        (w_route_valid),
        .w_route_sel          (w_route_sel),
        .w_route_id           (w_route_id),
        .w_route_pop          (w_route_pop),
        .dec_err              (dec_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: one holding slot and an ordered list of route entries.
    logic        m_hold_valid;
    logic [1:0]  m_hold_sel;
    logic [30:0] m_payload;
    logic        m_dec_err;
    logic [7:0]  route_q [$];

    task automatic chk(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_hold_valid = 1'b0;
        m_hold_sel   = 2'd0;
        m_payload    = '0;
        m_dec_err    = 1'b0;
        route_q.delete();
    endtask

    function automatic logic ready_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return ready_s0;
            2'd1:    return ready_s1;
            2'd2:    return ready_s2;
            default: return 1'b0;
        endcase
    endfunction

    // Compare all outputs against the model for the current cycle, then
    // advance the model by the handshakes happening at the coming edge.
    task automatic step();
        logic       fire;
        logic       exp_ready;
        logic       acc;
        logic [1:0] in_sel;
        #1;
        fire      = m_hold_valid && ready_of(m_hold_sel);
        exp_ready = (!m_hold_valid || fire) && (route_q.size() < ROUTE_DEPTH);
        chk("awready",  s_axi_awready, exp_ready);
        chk("valid_s0", valid_s0, m_hold_valid && m_hold_sel == 2'd0);
        chk("valid_s1", valid_s1, m_hold_valid && m_hold_sel == 2'd1);
        chk("valid_s2", valid_s2, m_hold_valid && m_hold_sel == 2'd2);
        chk("payload_s0", {awaddr_s0, awlen_s0, awsize_s0, awburst_s0, awid_s0}, m_payload);
        chk("payload_s1", {awaddr_s1, awlen_s1, awsize_s1, awburst_s1, awid_s1}, m_payload);
        chk("payload_s2", {awaddr_s2, awlen_s2, awsize_s2, awburst_s2, awid_s2}, m_payload);
        chk("route_valid", w_route_valid, route_q.size() != 0);
        if (route_q.size() != 0) begin
            chk("route_sel", w_route_sel, route_q[0][7:6]);
            chk("route_id",  w_route_id,  route_q[0][5:0]);
        end
        chk("dec_err", dec_err, m_dec_err);

        in_sel = s_axi_awaddr[11:10];
        acc    = s_axi_awvalid && exp_ready;
        if (w_route_pop && route_q.size() != 0) void'(route_q.pop_front());
        if (acc) route_q.push_back({in_sel, s_axi_awid});
        m_dec_err = acc && (in_sel == 2'd3);
        if (acc && in_sel != 2'd3) begin
            m_hold_valid = 1'b1;
            m_hold_sel   = in_sel;
            m_payload    = {s_axi_awaddr, s_axi_awlen, s_axi_awsize,
                            s_axi_awburst, s_axi_awid};
        end else if (fire) begin
            m_hold_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_aw(input logic [11:0] addr, input logic [5:0] id);
        s_axi_awaddr  = addr;
        s_axi_awid    = id;
        s_axi_awlen   = 8'($urandom);
        s_axi_awsize  = 3'($urandom);
        s_axi_awburst = 2'($urandom);
        s_axi_awvalid = 1'b1;
    endtask

    task automatic set_ready(input logic r0, input logic r1, input logic r2);
        ready_s0 = r0;
        ready_s1 = r1;
        ready_s2 = r2;
    endtask

    // Pops until the model queue is empty; bounded by the FIFO depth.
    task automatic drain();
        s_axi_awvalid = 1'b0;
        w_route_pop   = 1'b1;
        set_ready(1'b1, 1'b1, 1'b1);
        repeat (ROUTE_DEPTH + 2) step();
        w_route_pop   = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_awready",     s_axi_awready, 1'b0);
        chk("rst_valid_s0",    valid_s0, 1'b0);
        chk("rst_valid_s1",    valid_s1, 1'b0);
        chk("rst_valid_s2",    valid_s2, 1'b0);
        chk("rst_route_valid", w_route_valid, 1'b0);
        chk("rst_dec_err",     dec_err, 1'b0);
        chk("rst_payload",     {awaddr_s0, awlen_s0, awsize_s0, awburst_s0, awid_s0}, 31'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awlen   = '0;
        s_axi_awsize  = '0;
        s_axi_awburst = '0;
        s_axi_awid    = '0;
        s_axi_awvalid = 1'b0;
        w_route_pop   = 1'b0;
        set_ready(1'b1, 1'b1, 1'b1);
        model_reset();

        // Reset state, with awvalid high to show awready stays low.
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b1;
        #1;
        check_reset_outputs();
        s_axi_awvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Single write to s1.
        drive_aw(12'h456, 6'd5);
        step();
        s_axi_awvalid = 1'b0;
        chk("single_valid_s1",  valid_s1, 1'b1);
        chk("single_awaddr_s1", awaddr_s1, 12'h456);
        chk("single_route_sel", w_route_sel, 2'b01);
        chk("single_route_id",  w_route_id, 6'd5);
        step();
        drain();

        // Backpressure on s2 for three cycles, second AW queued behind it.
        set_ready(1'b1, 1'b1, 1'b0);
        drive_aw(12'h800, 6'd12);
        step();
        drive_aw(12'h123, 6'd13);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid_s2",  valid_s2, 1'b1);
            chk("bp_awaddr_s2", awaddr_s2, 12'h800);
            chk("bp_awready",   s_axi_awready, 1'b0);
            step();
        end
        ready_s2 = 1'b1;
        #1;
        chk("bp_accept_on_ready", s_axi_awready, 1'b1);
        step();
        s_axi_awvalid = 1'b0;
        chk("bp_second_valid_s0", valid_s0, 1'b1);
        step();
        drain();

        // Decode error.
        drive_aw(12'hC00, 6'd9);
        step();
        s_axi_awvalid = 1'b0;
        chk("derr_pulse",     dec_err, 1'b1);
        chk("derr_no_valid",  {valid_s2, valid_s1, valid_s0}, 3'b000);
        chk("derr_route_sel", w_route_sel, 2'b11);
        chk("derr_route_id",  w_route_id, 6'd9);
        step();
        chk("derr_pulse_end", dec_err, 1'b0);
        drain();

        // Route FIFO fills after four accepts without pops.
        for (int i = 0; i < ROUTE_DEPTH; i++) begin
            drive_aw({2'(i % 3), 10'($urandom)}, 6'(20 + i));
            step();
        end
        drive_aw(12'h040, 6'd30);
        #1;
        chk("full_awready", s_axi_awready, 1'b0);
        w_route_pop = 1'b1;
        step();
        w_route_pop = 1'b0;
        #1;
        chk("full_pop_awready", s_axi_awready, 1'b1);
        step();
        drain();

        // Streaming: one accept per cycle with pops every cycle.
        w_route_pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_aw({2'(i % 3), 10'($urandom)}, 6'(40 + i));
            #1;
            chk("stream_awready", s_axi_awready, 1'b1);
            step();
        end
        drain();

        // Randomized traffic, backpressure and pops.
        for (int i = 0; i < 400; i++) begin
            drive_aw(12'($urandom), 6'($urandom));
            s_axi_awvalid = 1'($urandom_range(0, 1));
            set_ready($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                      $urandom_range(0, 9) < 7);
            w_route_pop = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        // Reset asserted while s0 holds an AW.
        set_ready(1'b0, 1'b1, 1'b1);
        drive_aw(12'h010, 6'd33);
        step();
        s_axi_awvalid = 1'b0;
        chk("midrst_pre_valid_s0", valid_s0, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ready(1'b1, 1'b1, 1'b1);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
